// File: rtl/not_pipe.sv
// Elastic pipeline of STAGES registers that stores each accepted word as in_a XOR mask.
// Every stage can fill a bubble while the output is stalled; flush and reset empty the pipe.
module not_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_a,
    input  logic [WIDTH-1:0]               mask,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out,
    output logic [$clog2(STAGES+1)-1:0]    occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    // Handshake: a word moves across a boundary on a rising edge where the sender's
    // valid and the receiver's ready are both high; valid never waits on ready.
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [STAGES:0]   rdy;
    logic [OCC_W-1:0]  occ;

    // A stage can take a word when it is empty or its own word moves on this edge.
    always_comb begin
        rdy[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            rdy[i] = !valid_q[i] || rdy[i+1];
        end
    end

    assign in_ready = rdy[0] && !reset && !flush;

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < STAGES; i++) begin
            data_d[i] = data_q[i];
        end
        if (flush) begin
            valid_d = '0;
        end else begin
            if (rdy[0]) begin
                valid_d[0] = in_valid;
                if (in_valid) begin
                    data_d[0] = in_a ^ mask;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (rdy[i]) begin
                    valid_d[i] = valid_q[i-1];
                    if (valid_q[i-1]) begin
                        data_d[i] = data_q[i-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ = occ + OCC_W'(valid_q[i]);
        end
    end

    assign occupancy = occ;
    assign out_valid = valid_q[STAGES-1];
    assign out       = data_q[STAGES-1];

endmodule

// File: tb/tb_not_pipe.sv
// Directed vectors on the default 16x2 pipe, then random traffic with scoreboards
// on an 8-bit 4-stage pipe and a 32-bit 1-stage pipe.
module tb_not_pipe;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] mask;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic [1:0]  occupancy;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_a, b_mask, b_out;
    logic [2:0]  b_occupancy;

    logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [31:0] c_in_a, c_mask, c_out;
    logic [0:0]  c_occupancy;

    logic [7:0]  exp_b_q[$];
    int          stamp_b_q[$];
    logic [31:0] exp_c_q[$];
    int          stamp_c_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    not_pipe #(.WIDTH(16), .STAGES(2)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .mask(mask), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .occupancy(occupancy)
    );

    not_pipe #(.WIDTH(8), .STAGES(4)) dut_b (
        .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_a(b_in_a), .mask(b_mask), .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out),
        .occupancy(b_occupancy)
    );

    not_pipe #(.WIDTH(32), .STAGES(1)) dut_c (
        .clk(clk), .reset(reset), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_a(c_in_a), .mask(c_mask), .out_valid(c_out_valid), .out_ready(c_out_ready), .out(c_out),
        .occupancy(c_occupancy)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic load_word(input logic [15:0] a, input logic [15:0] m);
        in_valid = 1'b1;
        in_a     = a;
        mask     = m;
        tick();
    endtask

    initial begin : main
        logic [15:0] s_in [3];
        logic [15:0] s_exp [3];
        logic [7:0]  b_w;
        logic [31:0] c_w;
        bit          unstalled;

        s_in[0]  = 16'h0000; s_in[1]  = 16'h1234; s_in[2]  = 16'hFFFF;
        s_exp[0] = 16'h0F0F; s_exp[1] = 16'h1D3B; s_exp[2] = 16'hF0F0;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_a = '0; mask = '0; out_ready = 1'b1;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_a = '0; b_mask = '0; b_out_ready = 1'b1;
        c_flush = 1'b0; c_in_valid = 1'b0; c_in_a = '0; c_mask = '0; c_out_ready = 1'b1;
        #1;
        check("rst_out", out, 16'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_occ", occupancy, 2'd0);
        check("rst_in_ready", in_ready, 1'b0);
        tick(); tick();
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // single word, full inversion, latency of two edges
        load_word(16'h00FF, 16'hFFFF);
        in_valid = 1'b0;
        check("lat_valid_e0", out_valid, 1'b0);
        check("lat_occ_e0", occupancy, 2'd1);
        tick();
        check("lat_valid_e1", out_valid, 1'b1);
        check("lat_out_e1", out, 16'hFF00);
        tick();
        check("lat_valid_e2", out_valid, 1'b0);

        // back-to-back stream
        mask = 16'h0F0F;
        for (int k = 0; k < 5; k++) begin
            in_valid = (k < 3);
            if (k < 3) begin
                in_a = s_in[k];
                check("stream_in_ready", in_ready, 1'b1);
            end
            tick();
            if (k == 0 || k == 4) begin
                check("stream_idle_valid", out_valid, 1'b0);
            end else begin
                check("stream_valid", out_valid, 1'b1);
                check("stream_out", out, s_exp[k-1]);
            end
        end

        // backpressure: fill, hold, drain
        out_ready = 1'b0;
        load_word(16'h1111, 16'hFFFF);
        load_word(16'h2222, 16'hFFFF);
        in_a = 16'h3333;
        check("bp_occ_full", occupancy, 2'd2);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_out_hold", out, 16'hEEEE);
        tick();
        check("bp_out_hold2", out, 16'hEEEE);
        check("bp_valid_hold2", out_valid, 1'b1);
        check("bp_occ_hold2", occupancy, 2'd2);
        out_ready = 1'b1;
        #1;
        check("bp_full_pass_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("bp_drain0", out, 16'hDDDD);
        tick();
        check("bp_drain1", out, 16'hCCCC);
        check("bp_drain1_valid", out_valid, 1'b1);
        tick();
        check("bp_empty_valid", out_valid, 1'b0);
        check("bp_empty_occ", occupancy, 2'd0);

        // flush with a word offered
        out_ready = 1'b0;
        load_word(16'h0101, 16'h0000);
        load_word(16'h0202, 16'h0000);
        flush = 1'b1;
        in_a  = 16'h0303;
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush_occ", occupancy, 2'd0);
        check("flush_valid", out_valid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("flush_no_stale", out_valid, 1'b0);
        end

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        load_word(16'h0A0A, 16'h0000);
        load_word(16'h0B0B, 16'h0000);
        in_valid = 1'b0;
        check("arst_occ_before", occupancy, 2'd2);
        reset = 1'b1;
        #1;
        check("arst_out", out, 16'h0);
        check("arst_valid", out_valid, 1'b0);
        check("arst_in_ready", in_ready, 1'b0);
        check("arst_occ", occupancy, 2'd0);
        reset = 1'b0;
        #1;
        check("arst_rel_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("arst_no_stale", out_valid, 1'b0);
        end
        load_word(16'hABCD, 16'h00FF);
        in_valid = 1'b0;
        check("arst_first_e0", out_valid, 1'b0);
        tick();
        check("arst_first_valid", out_valid, 1'b1);
        check("arst_first_out", out, 16'hAB32);

        // random traffic on the swept instances; second half keeps out_ready high
        for (int k = 0; k < 400; k++) begin
            unstalled   = (k >= 200 && k < 380);
            b_in_valid  = (k < 380) ? 1'($urandom_range(0, 1)) : 1'b0;
            b_in_a      = 8'($urandom);
            b_mask      = 8'($urandom);
            b_out_ready = (k >= 200) ? 1'b1 : 1'($urandom_range(0, 1));
            c_in_valid  = (k < 380) ? 1'($urandom_range(0, 1)) : 1'b0;
            c_in_a      = $urandom;
            c_mask      = $urandom;
            c_out_ready = (k >= 200) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (b_in_valid && b_in_ready) begin
                exp_b_q.push_back(b_in_a ^ b_mask);
                stamp_b_q.push_back(unstalled ? cyc : -1);
            end
            if (c_in_valid && c_in_ready) begin
                exp_c_q.push_back(c_in_a ^ c_mask);
                stamp_c_q.push_back(unstalled ? cyc : -1);
            end
            if (b_out_valid && b_out_ready) begin
                if (exp_b_q.size() == 0) begin
                    check("b_spurious_word", 1'b1, 1'b0);
                end else begin
                    b_w = exp_b_q.pop_front();
                    check("b_data", b_out, b_w);
                    if (stamp_b_q[0] >= 0) check("b_latency", cyc - stamp_b_q[0], 4);
                    void'(stamp_b_q.pop_front());
                end
            end
            if (c_out_valid && c_out_ready) begin
                if (exp_c_q.size() == 0) begin
                    check("c_spurious_word", 1'b1, 1'b0);
                end else begin
                    c_w = exp_c_q.pop_front();
                    check("c_data", c_out, c_w);
                    if (stamp_c_q[0] >= 0) check("c_latency", cyc - stamp_c_q[0], 1);
                    void'(stamp_c_q.pop_front());
                end
            end
            tick();
        end
        check("b_all_drained", exp_b_q.size(), 0);
        check("c_all_drained", exp_c_q.size(), 0);
        check("b_occ_end", b_occupancy, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
